// File: rtl/gate_arbiter_rv32i.sv
// Round-robin arbiter sharing one XOR/OR/AND datapath between two requesters; result 2 cycles after accept, held until taken.
// Response stall blocks new grants; GATE_ARB_ILLEGAL_EN adds rsp_err flagging and an illegal-op counter.
module gate_arbiter_rv32i #(
   parameter int WIDTH   = 32,
   parameter bit RR_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_in1,
   input  logic [WIDTH-1:0] req0_in2,
   input  logic [1:0]       req0_type,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_in1,
   input  logic [WIDTH-1:0] req1_in2,
   input  logic [1:0]       req1_type,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
`ifdef GATE_ARB_ILLEGAL_EN
   output logic [15:0]      illegal_cnt,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t           state, state_nxt;
   logic             prio, owner;
   logic             grant0, grant1, accept, rsp_hs;
   logic [WIDTH-1:0] op_in1, op_in2, result;
   logic [1:0]       op_type, sel_type;

   assign rsp_hs     = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
   assign accept     = grant0 | grant1;
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp0_valid = (state == RESP) && !owner;
   assign rsp1_valid = (state == RESP) && owner;
   assign busy       = (state != IDLE);
   assign sel_type   = grant1 ? req1_type : req0_type;

   always_comb begin
      state_nxt = state;
      grant0    = 1'b0;
      grant1    = 1'b0;
      case (state)
         IDLE: begin
            // Ready is gated by rst so nothing is granted while reset is held
            if (!rst) begin
               grant0 = req0_valid && (!req1_valid || !prio);
               grant1 = req1_valid && (!req0_valid || prio);
            end
            if (grant0 || grant1) state_nxt = EXEC;
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      result = '0;
      case (op_type)
         2'b00:   result = op_in1 ^ op_in2;
         2'b01:   result = op_in1 | op_in2;
         2'b10:   result = op_in1 & op_in2;
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio     <= RR_INIT;
         owner    <= 1'b0;
         op_in1   <= '0;
         op_in2   <= '0;
         op_type  <= 2'b00;
         rsp_data <= '0;
      end else begin
         if (accept) begin
            op_in1  <= grant1 ? req1_in1 : req0_in1;
            op_in2  <= grant1 ? req1_in2 : req0_in2;
            op_type <= sel_type;
            owner   <= grant1;
         end
         if (state == EXEC) rsp_data <= result;
         if (rsp_hs)        prio     <= ~owner;
      end
   end

`ifdef GATE_ARB_ILLEGAL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_err     <= 1'b0;
         illegal_cnt <= 16'h0000;
      end else begin
         if (state == EXEC) rsp_err <= (op_type == 2'b11);
         if (accept && (sel_type == 2'b11) && (illegal_cnt != 16'hFFFF))
            illegal_cnt <= illegal_cnt + 16'h0001;
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_gate_arbiter_rv32i.sv
// Directed bench for gate_arbiter_rv32i: inputs driven on the falling edge, outputs sampled 1ns later.
module tb_gate_arbiter_rv32i;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
   logic [1:0]  req0_type, req1_type;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp_data;
   logic        rsp_err, busy;
`ifdef GATE_ARB_ILLEGAL_EN
   logic [15:0] illegal_cnt;
   localparam logic EXP_ILL_ERR = 1'b1;
`else
   localparam logic EXP_ILL_ERR = 1'b0;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int acc_cyc, prev_acc;

   gate_arbiter_rv32i #(.WIDTH(32), .RR_INIT(1'b0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
      .req0_in2(req0_in2), .req0_type(req0_type),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
      .req1_in2(req1_in2), .req1_type(req1_type),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
`ifdef GATE_ARB_ILLEGAL_EN
      .illegal_cnt(illegal_cnt),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200us");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Full single transaction from one requester, response taken as soon as it appears
   task automatic run_op(input bit r, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic exp_err, input string tag);
      if (!r) begin req0_valid = 1; req0_type = t; req0_in1 = a; req0_in2 = b; end
      else    begin req1_valid = 1; req1_type = t; req1_in1 = a; req1_in2 = b; end
      #1;
      chk({tag, "_ready"}, r ? req1_ready : req0_ready, 1);
      acc_cyc = cyc;
      @(negedge clk);
      if (!r) req0_valid = 0; else req1_valid = 0;
      #1;
      chk({tag, "_exec_busy"}, busy, 1);
      chk({tag, "_exec_rspv"}, r ? rsp1_valid : rsp0_valid, 0);
      @(negedge clk);
      #1;
      chk({tag, "_rspv"}, r ? rsp1_valid : rsp0_valid, 1);
      chk({tag, "_other_rspv"}, r ? rsp0_valid : rsp1_valid, 0);
      chk({tag, "_data"}, rsp_data, exp);
      chk({tag, "_err"}, rsp_err, exp_err);
      if (!r) rsp0_ready = 1; else rsp1_ready = 1;
      @(negedge clk);
      if (!r) rsp0_ready = 0; else rsp1_ready = 0;
      #1;
      chk({tag, "_done_rspv"}, r ? rsp1_valid : rsp0_valid, 0);
      chk({tag, "_done_busy"}, busy, 0);
   endtask

   task automatic pulse_rst();
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      rst = 1;
      req0_valid = 1; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
      req0_in1 = '0; req0_in2 = '0; req0_type = 2'b00;
      req1_in1 = '0; req1_in2 = '0; req1_type = 2'b00;
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rsp0v", rsp0_valid, 0);
      chk("rst_rsp1v", rsp1_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_ready_held", req0_ready, 0);
`ifdef GATE_ARB_ILLEGAL_EN
      chk("rst_illcnt", illegal_cnt, 0);
`endif
      rst = 0;
      run_op(0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, "xor0");

      // Contention with prio back at RR_INIT
      pulse_rst();
      req0_valid = 1; req0_type = 2'b10; req0_in1 = 32'hFFFF0000; req0_in2 = 32'h12345678;
      req1_valid = 1; req1_type = 2'b01; req1_in1 = 32'h00000001; req1_in2 = 32'h00000002;
      #1;
      chk("both_r0", req0_ready, 1);
      chk("both_r1", req1_ready, 0);
      @(negedge clk);
      req0_valid = 0;
      #1;
      chk("both_exec_r1", req1_ready, 0);
      @(negedge clk);
      #1;
      chk("both_rsp0v", rsp0_valid, 1);
      chk("both_rsp1v", rsp1_valid, 0);
      chk("both_data0", rsp_data, 32'h12340000);
      chk("both_resp_r1", req1_ready, 0);
      rsp0_ready = 1;
      @(negedge clk);
      rsp0_ready = 0;
      req0_valid = 1;
      #1;
      chk("prio1_r1", req1_ready, 1);
      chk("prio1_r0", req0_ready, 0);
      @(negedge clk);
      req1_valid = 0;
      @(negedge clk);
      #1;
      chk("both_rsp1v_b", rsp1_valid, 1);
      chk("both_data1", rsp_data, 32'h00000003);
      rsp1_ready = 1;
      @(negedge clk);
      rsp1_ready = 0;
      req1_valid = 1;
      #1;
      chk("prio0_r0", req0_ready, 1);
      chk("prio0_r1", req1_ready, 0);
      req0_valid = 0;
      req1_valid = 0;

      // Response stall from req1 while req0 waits
      @(negedge clk);
      req1_valid = 1; req1_type = 2'b01; req1_in1 = 32'h00FF0000; req1_in2 = 32'h000000FF;
      #1;
      chk("bp_accept", req1_ready, 1);
      @(negedge clk);
      req1_valid = 0;
      req0_valid = 1; req0_type = 2'b00; req0_in1 = 32'h1; req0_in2 = 32'h2;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_rsp1v", rsp1_valid, 1);
         chk("bp_data", rsp_data, 32'h00FF00FF);
         chk("bp_r0", req0_ready, 0);
         chk("bp_busy", busy, 1);
         @(negedge clk);
      end
      rsp1_ready = 1;
      #1;
      chk("bp_hs_r0", req0_ready, 0);
      @(negedge clk);
      rsp1_ready = 0;
      #1;
      chk("bp_after_r0", req0_ready, 1);
      req0_valid = 0;
      #1;
      chk("withdraw_r0", req0_ready, 0);

      // Reset while the op is in EXEC
      @(negedge clk);
      req0_valid = 1; req0_type = 2'b01; req0_in1 = 32'h0000FFFF; req0_in2 = 32'hFFFF0000;
      @(negedge clk);
      req0_valid = 0;
      rst = 1;
      #1;
      chk("rexec_busy", busy, 0);
      chk("rexec_rsp0v", rsp0_valid, 0);
      chk("rexec_data", rsp_data, 0);
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("rexec_no_rsp", rsp0_valid, 0);
         @(negedge clk);
      end
      run_op(1, 2'b10, 32'hCAFEBABE, 32'hFFFF0000, 32'hCAFE0000, 0, "post_rst");

      run_op(0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, EXP_ILL_ERR, "illegal");
`ifdef GATE_ARB_ILLEGAL_EN
      chk("illegal_cnt", illegal_cnt, 1);
`endif

      // Back-to-back req0 with response always accepted
      rsp0_ready = 1;
      run_op(0, 2'b00, 32'hAAAA5555, 32'h0F0F0F0F, 32'hA5A55A5A, 0, "b2b_0");
      prev_acc = acc_cyc;
      rsp0_ready = 1;
      run_op(0, 2'b01, 32'h12340000, 32'h00005678, 32'h12345678, 0, "b2b_1");
      chk("b2b_gap1", acc_cyc - prev_acc, 3);
      prev_acc = acc_cyc;
      rsp0_ready = 1;
      run_op(0, 2'b10, 32'hDEADBEEF, 32'h0000FFFF, 32'h0000BEEF, 0, "b2b_2");
      chk("b2b_gap2", acc_cyc - prev_acc, 3);
      prev_acc = acc_cyc;
      rsp0_ready = 1;
      run_op(0, 2'b00, 32'h80000001, 32'h80000001, 32'h00000000, 0, "b2b_3");
      chk("b2b_gap3", acc_cyc - prev_acc, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
